// File: rtl/arrow_scheduler.sv
// arrow_scheduler: plays a 4-bit arrow chart, one entry per beat, through a valid/ready output.
// Build option: define ARROW_LOOP_EN to replay the chart continuously instead of stopping in DONE.
module arrow_scheduler #(
    parameter int BEAT_DIV  = 50000000,
    parameter int CHART_LEN = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         wr_en,
    input  logic [$clog2(CHART_LEN)-1:0] wr_addr,
    input  logic [3:0]                   wr_data,
    output logic [3:0]                   arrows,
    output logic                         arrows_valid,
    input  logic                         arrows_ready,
    output logic                         beat,
    output logic [$clog2(CHART_LEN)-1:0] index,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int ADDR_W = $clog2(CHART_LEN);
    localparam int CNT_W  = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEAT_DIV - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(CHART_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] idx_d;
    logic [3:0]        arrows_d;
    logic              valid_d;
    logic              beat_d;
    logic              busy_d;
    logic              done_d;
    logic              ovr_d;
    logic              chart_we;
    logic [3:0]        entry;
    logic [3:0]        chart [CHART_LEN];

    // Chart storage has no reset so its contents survive a Reset pulse.
    always_ff @(posedge Clk) begin
        if (chart_we) begin
            chart[wr_addr] <= wr_data;
        end
    end

    assign entry = chart[index];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = index;
        arrows_d = arrows;
        valid_d  = arrows_valid;
        beat_d   = 1'b0;
        ovr_d    = 1'b0;
        chart_we = 1'b0;

        if (arrows_valid && arrows_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                chart_we = wr_en;
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_RUN, S_PAUSE: begin
                // Leaving PAUSE counts in the same cycle, so a pause of N cycles delays by exactly N.
                if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        beat_d = 1'b1;
                        idx_d  = index + ADDR_W'(1);
                        if (entry != '0) begin
                            arrows_d = entry;
                            valid_d  = 1'b1;
                            ovr_d    = arrows_valid && !arrows_ready;
                        end
                        if (index == IDX_LAST) begin
`ifdef ARROW_LOOP_EN
                            state_d = S_RUN;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            index        <= '0;
            arrows       <= '0;
            arrows_valid <= 1'b0;
            beat         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            index        <= idx_d;
            arrows       <= arrows_d;
            arrows_valid <= valid_d;
            beat         <= beat_d;
            busy         <= busy_d;
            done         <= done_d;
            overrun      <= ovr_d;
        end
    end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Testbench for arrow_scheduler: vector table, directed corner sequences, random run vs reference model.
module tb_arrow_scheduler;

    localparam int BD = 4;
    localparam int CL = 4;
`ifdef ARROW_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       arrows_ready = 1'b0;
    logic [3:0] arrows;
    logic       arrows_valid;
    logic       beat;
    logic [1:0] index;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [10:0] dv;

    int checks = 0;
    int failures = 0;

    arrow_scheduler #(.BEAT_DIV(BD), .CHART_LEN(CL)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .pause(pause),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .arrows(arrows), .arrows_valid(arrows_valid), .arrows_ready(arrows_ready),
        .beat(beat), .index(index), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    assign dv = {arrows, arrows_valid, beat, index, busy, done, overrun};

    function automatic logic [10:0] mk(logic [3:0] a, logic v, logic b, logic [1:0] i,
                                       logic bz, logic dn, logic ov);
        return {a, v, b, i, bz, dn, ov};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: counts run cycles and beats played since start.
    int         m_chart [CL];
    int         m_phase;   // 0 idle, 1 playing (run or pause), 2 finished
    int         m_active;
    int         m_played;
    bit         m_valid;
    bit [3:0]   m_arrows;
    bit         m_beat;
    bit         m_ovr;

    task automatic model_reset();
        m_phase = 0; m_active = 0; m_played = 0;
        m_valid = 0; m_arrows = '0; m_beat = 0; m_ovr = 0;
    endtask

    task automatic model_edge();
        bit fire = m_valid && arrows_ready;
        bit loaded = 0;
        m_beat = 0;
        m_ovr  = 0;
        if (m_phase != 1) begin
            if (wr_en) m_chart[wr_addr] = int'(wr_data);
            if (start) begin
                m_phase = 1; m_active = 0; m_played = 0;
            end
        end else if (!pause) begin
            m_active++;
            if (m_active % BD == 0) begin
                int e = m_chart[m_played % CL];
                m_beat = 1;
                m_played++;
                if (e != 0) begin
                    m_ovr = m_valid && !arrows_ready;
                    m_arrows = 4'(e);
                    m_valid = 1;
                    loaded = 1;
                end
                if (!LOOP && (m_played % CL == 0)) m_phase = 2;
            end
        end
        if (fire && !loaded) m_valid = 0;
    endtask

    function automatic logic [10:0] model_vec();
        return mk(m_arrows, m_valid, m_beat, 2'(m_played % CL), m_phase == 1, m_phase == 2, m_ovr);
    endfunction

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        #2 Reset = 1'b0;
        model_reset();
    endtask

    task automatic wr(int a, logic [3:0] d);
        wr_en = 1'b1; wr_addr = 2'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    typedef struct {
        bit         st;
        bit         we;
        bit [1:0]   wa;
        bit [3:0]   wd;
        logic [10:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(bit st, bit we, int wa, logic [3:0] wd, logic [10:0] exp);
        vec_t v;
        v.st = st; v.we = we; v.wa = 2'(wa); v.wd = wd; v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ch [CL];
        ch[0] = 4'b0100; ch[1] = 4'b1111; ch[2] = 4'b0001; ch[3] = 4'b1000;
        model_reset();
        for (int i = 0; i < CL; i++) m_chart[i] = 0;

        #2 chk("reset_state", 32'(dv), 32'(0));
        #10 Reset = 1'b0;

        // Full playback with ready held high; cycle 0 is the start edge.
        for (int i = 0; i < CL; i++) add(0, 1, i, ch[i], mk(4'h0, 0, 0, 2'd0, 0, 0, 0));
        add(1, 0, 0, 4'h0, mk(4'h0, 0, 0, 2'd0, 1, 0, 0));
        for (int c = 1; c <= 3; c++) add(0, 0, 0, 4'h0, mk(4'h0, 0, 0, 2'd0, 1, 0, 0));
        for (int b = 0; b < 3; b++) begin
            add(0, 0, 0, 4'h0, mk(ch[b], 1, 1, 2'(b + 1), 1, 0, 0));
            for (int c = 1; c <= 3; c++) add(0, 0, 0, 4'h0, mk(ch[b], 0, 0, 2'(b + 1), 1, 0, 0));
        end
        add(0, 0, 0, 4'h0, mk(ch[3], 1, 1, 2'd0, LOOP, !LOOP, 0));
        for (int c = 17; c <= 19; c++) add(0, 0, 0, 4'h0, mk(ch[3], 0, 0, 2'd0, LOOP, !LOOP, 0));
        if (LOOP) add(0, 0, 0, 4'h0, mk(ch[0], 1, 1, 2'd1, 1, 0, 0));
        else      add(0, 0, 0, 4'h0, mk(ch[3], 0, 0, 2'd0, 0, 1, 0));

        arrows_ready = 1'b1;
        foreach (vq[i]) begin
            start = vq[i].st; wr_en = vq[i].we; wr_addr = vq[i].wa; wr_data = vq[i].wd;
            step();
            chk($sformatf("vec%0d", i), 32'(dv), 32'(vq[i].exp));
        end
        start = 1'b0; wr_en = 1'b0;

        // Zero chart entry: beat still advances index, no valid.
        do_reset();
        wr(0, 4'b0100); wr(1, 4'b0000); wr(2, 4'b0001); wr(3, 4'b1000);
        arrows_ready = 1'b1;
        go();
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 7) chk("zero_idx_before", 32'(index), 32'(1));
            if (c == 8) begin
                chk("zero_beat", 32'(beat), 32'(1));
                chk("zero_idx_after", 32'(index), 32'(2));
                chk("zero_valid", 32'(arrows_valid), 32'(0));
                chk("zero_arrows", 32'(arrows), 32'(4'b0100));
            end
        end

        // Overrun: ready low across beats 1 and 2.
        do_reset();
        wr(1, 4'b1111);
        arrows_ready = 1'b0;
        go();
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 4) chk("ovr_first", 32'({overrun, arrows_valid}), 32'(2'b01));
        end
        chk("ovr_pulse", 32'({overrun, arrows_valid, arrows}), 32'({2'b11, 4'b1111}));
        step();
        chk("ovr_clear", 32'({overrun, arrows_valid, arrows}), 32'({2'b01, 4'b1111}));
        arrows_ready = 1'b1;
        step();
        chk("ovr_drain", 32'(arrows_valid), 32'(0));

        // Pause after count reaches 2; write during pause must be dropped.
        do_reset();
        arrows_ready = 1'b1;
        go();
        step(); step();
        pause = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'b1010;
        for (int c = 3; c <= 8; c++) begin
            step();
            chk($sformatf("pause_c%0d", c), 32'({beat, busy}), 32'(2'b01));
        end
        pause = 1'b0; wr_en = 1'b0;
        step();
        chk("pause_c9", 32'(beat), 32'(0));
        step();
        chk("pause_beat", 32'({beat, arrows_valid, arrows}), 32'({2'b11, 4'b0100}));

        // Asynchronous reset with a pending pattern; chart survives.
        do_reset();
        arrows_ready = 1'b0;
        go();
        for (int c = 1; c <= 5; c++) step();
        chk("pend_before_rst", 32'({arrows_valid, arrows}), 32'({1'b1, 4'b0100}));
        #3 Reset = 1'b1;
        #1 chk("rst_async", 32'(dv), 32'(0));
        Reset = 1'b0;
        model_reset();
        go();
        for (int c = 1; c <= 4; c++) step();
        chk("chart_retained", 32'({beat, arrows}), 32'({1'b1, 4'b0100}));

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            start        = ($urandom % 16) == 0;
            pause        = ($urandom % 8) == 0;
            wr_en        = ($urandom % 3) == 0;
            wr_addr      = 2'($urandom);
            wr_data      = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
            arrows_ready = ($urandom % 2) == 0;
            if (($urandom % 600) == 0) do_reset();
            step();
            chk($sformatf("rand%0d", i), 32'(dv), 32'(model_vec()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
